// File: rtl/fpu_types_pkg.sv
// Shared widths, constants and types for the half-precision FPU datapath.
// normalize() is the stage-1 step that turns a raw product into norm_t.
package fpu_types_pkg;

    localparam int HALF_FLOAT_W    = 16;
    localparam int HALF_EXPONENT_W = 5;
    localparam int HALF_FRACTION_W = 10;
    localparam int HALF_BIAS       = 15;

    localparam logic [HALF_FLOAT_W-1:0] HALF_INF  = 16'h7C00;
    localparam logic [HALF_FLOAT_W-1:0] HALF_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        SPECIAL_NORMAL = 2'b00,
        SPECIAL_ZERO   = 2'b01,
        SPECIAL_INF    = 2'b10,
        SPECIAL_NAN    = 2'b11
    } special_t;

    typedef struct packed {
        logic                       sign;
        logic [7:0]                 e;
        logic [HALF_FRACTION_W-1:0] m;
        logic                       g;
        logic                       s;
        special_t                   special;
    } norm_t;

    // The product of two 1.x significands lies in [1,4); bit 21 says which half.
    function automatic norm_t normalize(
        input logic     sign,
        input logic [5:0]  exp_sum,
        input logic [21:0] mant_prod,
        input special_t special
    );
        norm_t n;
        logic  hi;
        hi        = mant_prod[21];
        n.sign    = sign;
        n.special = special;
        n.e       = {2'b00, exp_sum} - 8'(HALF_BIAS) + {7'd0, hi};
        if (hi) begin
            n.m = mant_prod[20:11];
            n.g = mant_prod[10];
            n.s = |mant_prod[9:0];
        end else begin
            n.m = mant_prod[19:10];
            n.g = mant_prod[9];
            n.s = |mant_prod[8:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and binary16 packing of a normalized product.
// Overflow saturates to infinity; results below the normal range flush to signed zero.
module fp16_round_pack
    import fpu_types_pkg::*;
(
    input  norm_t                    norm,
    output logic [HALF_FLOAT_W-1:0]  product,
    output logic [2:0]               flags
);

    logic                       rup;
    logic                       carry;
    logic [HALF_FRACTION_W-1:0] mant_r;
    logic signed [7:0]          exp_f;
    logic                       inexact;

    always_comb begin
        rup             = norm.g & (norm.s | norm.m[0]);
        {carry, mant_r} = {1'b0, norm.m} + {10'd0, rup};
        exp_f           = $signed(norm.e) + $signed({7'd0, carry});
        inexact         = norm.g | norm.s;
        product         = '0;
        flags           = 3'b000;

        // Specials classified upstream take priority over whatever the arithmetic says.
        case (norm.special)
            SPECIAL_ZERO: product = {norm.sign, 15'h0};
            SPECIAL_INF:  product = {norm.sign, HALF_INF[14:0]};
            SPECIAL_NAN:  product = HALF_QNAN;
            default: begin
                if (exp_f >= 8'sd31) begin
                    product = {norm.sign, HALF_INF[14:0]};
                    flags   = 3'b101;
                end else if (exp_f <= 8'sd0) begin
                    product = {norm.sign, 15'h0};
                    flags   = 3'b011;
                end else begin
                    product = {norm.sign, exp_f[HALF_EXPONENT_W-1:0], mant_r};
                    flags   = {2'b00, inexact};
                end
            end
        endcase
    end

endmodule

// File: rtl/float_mult_16bit_round.sv
// Normalize/round/pack stage of the half-precision multiplier: two registered stages
// with a valid/ready handshake that sustains one result per cycle and stalls cleanly.
module float_mult_16bit_round
    import fpu_types_pkg::*;
(
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [5:0]               in_exp_sum,
    input  logic [21:0]              in_mant_prod,
    input  logic [1:0]               in_special,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [HALF_FLOAT_W-1:0]  product,
    output logic [2:0]               flags
);

    norm_t                    s1_next;
    norm_t                    s1_data;
    logic                     s1_valid;
    logic                     s1_en;
    logic                     s2_en;
    logic [HALF_FLOAT_W-1:0]  rp_product;
    logic [2:0]               rp_flags;

    // Each stage advances when the stage after it is empty or being drained this cycle.
    assign s2_en    = ~out_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;

    assign s1_next = normalize(in_sign, in_exp_sum, in_mant_prod, special_t'(in_special));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= s1_next;
            end
        end
    end

    fp16_round_pack u_round_pack (
        .norm    (s1_data),
        .product (rp_product),
        .flags   (rp_flags)
    );

    // Product and flags only load with a real result, so they hold while out_valid is low.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            product   <= '0;
            flags     <= 3'b000;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                product <= rp_product;
                flags   <= rp_flags;
            end
        end
    end

endmodule

// File: tb/tb_float_mult_16bit_round.sv
// Self-checking bench: a vector table of raw products with hand-computed binary16 results,
// a scoreboard queue for ordering, plus backpressure and mid-stream reset sequences.
module tb_float_mult_16bit_round;

    typedef struct {
        logic        sign;
        logic [5:0]  exp_sum;
        logic [21:0] mant_prod;
        logic [1:0]  special;
        logic [15:0] product;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [15:0] product;
        logic [2:0]  flags;
    } exp_t;

    localparam int NV = 19;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [5:0]  in_exp_sum;
    logic [21:0] in_mant_prod;
    logic [1:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic [2:0]  flags;

    vec_t vecs [NV];
    exp_t sb_q [$];
    exp_t exp_in;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic stim_done;

    float_mult_16bit_round dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp_sum   (in_exp_sum),
        .in_mant_prod (in_mant_prod),
        .in_special   (in_special),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .flags        (flags)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Transfers are decided at the coming rising edge, so both sides are sampled mid-cycle.
    always @(negedge CLK) begin
        if (nRST) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got product %h flags %b, expected no output", product, flags);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (product !== e.product || flags !== e.flags) begin
                        n_fail++;
                        $display("[TB] FAIL scoreboard: got product %h flags %b, expected product %h flags %b",
                                 product, flags, e.product, e.flags);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(exp_in);
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic drive_inputs(input vec_t v);
        in_valid     = 1'b1;
        in_sign      = v.sign;
        in_exp_sum   = v.exp_sum;
        in_mant_prod = v.mant_prod;
        in_special   = v.special;
        exp_in       = '{v.product, v.flags};
    endtask

    task automatic apply_stimulus(input vec_t v);
        int   waited = 0;
        logic acc    = 1'b0;
        drive_inputs(v);
        while (!acc && waited < 100) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK);
            #1;
            waited++;
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready low for %0d cycles, expected accept", waited);
        end
    endtask

    task automatic wait_drain();
        int cyc = 0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || out_valid) && cyc < 200) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        n_cmp++;
        if (sb_q.size() != 0 || out_valid) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d results pending out_valid %b, expected 0 pending", sb_q.size(), out_valid);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 6'd30, 22'h100000, 2'b00, 16'h3C00, 3'b000};
        vecs[1]  = '{1'b0, 6'd30, 22'h240000, 2'b00, 16'h4080, 3'b000};
        vecs[2]  = '{1'b0, 6'd30, 22'h100200, 2'b00, 16'h3C00, 3'b001};
        vecs[3]  = '{1'b0, 6'd30, 22'h100600, 2'b00, 16'h3C02, 3'b001};
        vecs[4]  = '{1'b0, 6'd30, 22'h1FFE00, 2'b00, 16'h4000, 3'b001};
        vecs[5]  = '{1'b0, 6'd60, 22'h100000, 2'b00, 16'h7C00, 3'b101};
        vecs[6]  = '{1'b1, 6'd10, 22'h100000, 2'b00, 16'h8000, 3'b011};
        vecs[7]  = '{1'b0, 6'd20, 22'h123456, 2'b11, 16'h7E00, 3'b000};
        vecs[8]  = '{1'b1, 6'd30, 22'h100000, 2'b10, 16'hFC00, 3'b000};
        vecs[9]  = '{1'b1, 6'd60, 22'h3FFFFF, 2'b01, 16'h8000, 3'b000};
        vecs[10] = '{1'b0, 6'd45, 22'h1FFE00, 2'b00, 16'h7C00, 3'b101};
        vecs[11] = '{1'b0, 6'd45, 22'h100000, 2'b00, 16'h7800, 3'b000};
        vecs[12] = '{1'b0, 6'd15, 22'h100000, 2'b00, 16'h0000, 3'b011};
        vecs[13] = '{1'b0, 6'd16, 22'h100000, 2'b00, 16'h0400, 3'b000};
        vecs[14] = '{1'b0, 6'd15, 22'h1FFE00, 2'b00, 16'h0400, 3'b001};
        vecs[15] = '{1'b0, 6'd30, 22'h200C00, 2'b00, 16'h4002, 3'b001};
        vecs[16] = '{1'b1, 6'd30, 22'h200401, 2'b00, 16'hC001, 3'b001};
        vecs[17] = '{1'b0, 6'd44, 22'h3FFFFF, 2'b00, 16'h7C00, 3'b101};
        vecs[18] = '{1'b0, 6'd0,  22'h3FFFFF, 2'b00, 16'h0000, 3'b011};

        nRST         = 1'b0;
        in_valid     = 1'b0;
        in_sign      = 1'b0;
        in_exp_sum   = '0;
        in_mant_prod = '0;
        in_special   = '0;
        out_ready    = 1'b1;
        exp_in       = '{16'h0, 3'b000};
        stim_done    = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check_output("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check_output("reset_product", product, 16'h0000);
        check_output("reset_flags", {13'd0, flags}, 16'd0);
        check_output("reset_in_ready", {15'd0, in_ready}, 16'd1);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] latency check");
        apply_stimulus(vecs[0]);
        in_valid = 1'b0;
        check_output("latency_stage1", {15'd0, out_valid}, 16'd0);
        @(posedge CLK);
        #1;
        check_output("latency_out_valid", {15'd0, out_valid}, 16'd1);
        check_output("latency_product", product, 16'h3C00);
        wait_drain();

        $display("[TB] vector table, back to back");
        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i]);
        end
        in_valid = 1'b0;
        wait_drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        drive_inputs(vecs[1]);
        check_output("bp_ready_first", {15'd0, in_ready}, 16'd1);
        @(posedge CLK);
        #1;
        drive_inputs(vecs[3]);
        check_output("bp_ready_second", {15'd0, in_ready}, 16'd1);
        @(posedge CLK);
        #1;
        drive_inputs(vecs[5]);
        for (int k = 0; k < 3; k++) begin
            check_output("bp_ready_stalled", {15'd0, in_ready}, 16'd0);
            check_output("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            check_output("bp_hold_product", product, vecs[1].product);
            check_output("bp_hold_flags", {13'd0, flags}, {13'd0, vecs[1].flags});
            @(posedge CLK);
            #1;
        end
        out_ready = 1'b1;
        apply_stimulus(vecs[5]);
        apply_stimulus(vecs[16]);
        in_valid = 1'b0;
        wait_drain();

        $display("[TB] random traffic with random out_ready");
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    apply_stimulus(vecs[$urandom_range(0, NV - 1)]);
                end
                in_valid  = 1'b0;
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        wait_drain();

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        drive_inputs(vecs[0]);
        @(posedge CLK);
        #1;
        drive_inputs(vecs[4]);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        nRST     = 1'b0;
        #1;
        check_output("rst_mid_out_valid", {15'd0, out_valid}, 16'd0);
        check_output("rst_mid_product", product, 16'h0000);
        check_output("rst_mid_flags", {13'd0, flags}, 16'd0);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        check_output("rst_post_idle", {15'd0, out_valid}, 16'd0);
        apply_stimulus(vecs[1]);
        in_valid = 1'b0;
        check_output("rst_post_stage1", {15'd0, out_valid}, 16'd0);
        @(posedge CLK);
        #1;
        check_output("rst_post_out_valid", {15'd0, out_valid}, 16'd1);
        check_output("rst_post_product", product, 16'h4080);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
